timer_counter: RTL and testbench

//  Time-base stage of the timer peripheral: owns TCNT, TCR, TPSC and TARR, runs the prescaler and
//  the up-counter with auto-reload, and raises the update (overflow) flag/interrupt.

---
 rtl/timer_counter.sv | 163 ++++++++++++++++
 tb/tb_timer_counter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Time base of the timer peripheral: holds TCNT/TCR/TPSC/TARR, runs the
// prescaler and the auto-reload up-counter, and raises the update flag and
// interrupt. The next-cycle values of TCNT and TCR are exported
// combinationally so that capture/compare channels can detect counter motion.
//
// Bus write protocol: a write is a single-cycle event. When wen is high at a
// rising clk edge, the register whose one-hot reg_select bit is set takes
// (wdata & strobe_expanded). There is no ready/back-pressure; every write is
// accepted in the cycle it is presented. With wen low, nothing changes.
module timer_counter #(
  parameter int BITS_WIDTH    = 32,
  parameter int NUM_REGISTERS = 20,
  parameter int TCNT_IND      = 0,
  parameter int TCR_IND       = 1,
  parameter int TPSC_IND      = 2,
  parameter int TARR_IND      = 3
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wen,
  input  logic [BITS_WIDTH-1:0]    wdata,
  input  logic [BITS_WIDTH-1:0]    strobe_expanded,
  input  logic [NUM_REGISTERS-1:0] reg_select,
  output logic [BITS_WIDTH-1:0]    tcnt,
  output logic [BITS_WIDTH-1:0]    nxt_tcnt,
  output logic [BITS_WIDTH-1:0]    tcr,
  output logic [BITS_WIDTH-1:0]    nxt_tcr,
  output logic [BITS_WIDTH-1:0]    tpsc,
  output logic [BITS_WIDTH-1:0]    tarr,
  output logic                     t_uirq
);

  // TCR bit positions
  localparam int RST_B  = 0;
  localparam int OPM_B  = 1;
  localparam int UIE_B  = 2;
  localparam int ARPE_B = 4;
  localparam int EN_B   = 7;
  localparam int UIF_B  = 8;

  // Bits that a TCR write loads directly (UIF is write-1-to-clear instead)
  localparam logic [BITS_WIDTH-1:0] WR_MASK  = BITS_WIDTH'(9'h097);
  localparam logic [BITS_WIDTH-1:0] UIF_MASK = BITS_WIDTH'(9'h100);
  localparam logic [BITS_WIDTH-1:0] ONE      = BITS_WIDTH'(1);

  logic [BITS_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [BITS_WIDTH-1:0] tcr_q, tcr_d;
  logic [BITS_WIDTH-1:0] tpsc_q, tpsc_d;
  logic [BITS_WIDTH-1:0] tarr_q, tarr_d;
  logic [BITS_WIDTH-1:0] arr_shadow_q, arr_shadow_d;
  logic [BITS_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic                  t_uirq_q, t_uirq_d;

  logic [BITS_WIDTH-1:0] wr_val;
  logic                  wr_tcnt, wr_tcr, wr_tpsc, wr_tarr;
  logic                  tick, ovf;
  logic                  unused_sel;

  // Only four of the select lines address this block
  assign unused_sel = ^reg_select;

  // Decode bus writes to this block's registers
  always_comb begin
    wr_val  = wdata & strobe_expanded;
    wr_tcnt = wen & reg_select[TCNT_IND];
    wr_tcr  = wen & reg_select[TCR_IND];
    wr_tpsc = wen & reg_select[TPSC_IND];
    wr_tarr = wen & reg_select[TARR_IND];
  end

  // Prescaler tick and overflow detection; >= keeps both safe when the
  // limits are lowered below the running counts
  always_comb begin
    tick = tcr_q[EN_B] && (psc_cnt_q >= tpsc_q);
    ovf  = tick && !tcr_q[RST_B] && !wr_tcnt && (tcnt_q >= tarr_q);
  end

  // Next counter value: RST, then bus write, then tick, then hold
  always_comb begin
    tcnt_d = tcnt_q;
    if (tcr_q[RST_B]) begin
      tcnt_d = '0;
    end else if (wr_tcnt) begin
      tcnt_d = wr_val;
    end else if (tick) begin
      tcnt_d = ovf ? '0 : (tcnt_q + ONE);
    end
  end

  // Prescaler counter: cleared by RST or a tick, frozen while disabled
  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (tcr_q[RST_B]) begin
      psc_cnt_d = '0;
    end else if (tick) begin
      psc_cnt_d = '0;
    end else if (tcr_q[EN_B]) begin
      psc_cnt_d = psc_cnt_q + ONE;
    end
  end

  // Next control value: RST self-clears, UIF is sticky/W1C with hardware set
  // winning, OPM drops EN on overflow unless software writes TCR that cycle
  always_comb begin
    tcr_d        = tcr_q & (WR_MASK | UIF_MASK);
    tcr_d[RST_B] = 1'b0;
    if (wr_tcr) begin
      tcr_d = (wr_val & WR_MASK) | (tcr_q & UIF_MASK);
      if (wr_val[UIF_B]) begin
        tcr_d[UIF_B] = 1'b0;
      end
    end
    if (ovf) begin
      tcr_d[UIF_B] = 1'b1;
      if (tcr_q[OPM_B] && !wr_tcr) begin
        tcr_d[EN_B] = 1'b0;
      end
    end
  end

  // Prescaler reload, auto-reload shadow and active reload value
  always_comb begin
    tpsc_d       = wr_tpsc ? wr_val : tpsc_q;
    arr_shadow_d = wr_tarr ? wr_val : arr_shadow_q;
    tarr_d       = tarr_q;
    if (wr_tarr && !tcr_q[ARPE_B]) begin
      tarr_d = wr_val;
    end else if (ovf && tcr_q[ARPE_B]) begin
      tarr_d = arr_shadow_q;
    end
    t_uirq_d = tcr_d[UIF_B] & tcr_d[UIE_B];
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tcnt_q       <= '0;
      tcr_q        <= '0;
      tpsc_q       <= '0;
      tarr_q       <= '1;
      arr_shadow_q <= '0;
      psc_cnt_q    <= '0;
      t_uirq_q     <= 1'b0;
    end else begin
      tcnt_q       <= tcnt_d;
      tcr_q        <= tcr_d;
      tpsc_q       <= tpsc_d;
      tarr_q       <= tarr_d;
      arr_shadow_q <= arr_shadow_d;
      psc_cnt_q    <= psc_cnt_d;
      t_uirq_q     <= t_uirq_d;
    end
  end

  assign tcnt     = tcnt_q;
  assign nxt_tcnt = tcnt_d;
  assign tcr      = tcr_q;
  assign nxt_tcr  = tcr_d;
  assign tpsc     = tpsc_q;
  assign tarr     = tarr_q;
  assign t_uirq   = t_uirq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences, all checked through an expected queue.
module tb_timer_counter;

  localparam int W   = 32;
  localparam int NR  = 20;
  localparam int SBW = 3 * W + 1;
  localparam int I_TCNT = 0;
  localparam int I_TCR  = 1;
  localparam int I_TPSC = 2;
  localparam int I_TARR = 3;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          wen;
  logic [W-1:0]  wdata;
  logic [W-1:0]  strobe_expanded;
  logic [NR-1:0] reg_select;
  logic [W-1:0]  tcnt, nxt_tcnt, tcr, nxt_tcr, tpsc, tarr;
  logic          t_uirq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SBW-1:0] exp_q[$];
  string          name_q[$];

  typedef struct {
    logic         w;
    int           idx;
    logic [W-1:0] d;
    logic [W-1:0] stb;
    logic [W-1:0] e_tcnt;
    logic [W-1:0] e_tcr;
    logic [W-1:0] e_tarr;
    logic         e_u;
  } vec_t;

  vec_t vecs[$];

  timer_counter #(
    .BITS_WIDTH(W), .NUM_REGISTERS(NR),
    .TCNT_IND(I_TCNT), .TCR_IND(I_TCR), .TPSC_IND(I_TPSC), .TARR_IND(I_TARR)
  ) dut (
    .clk(clk), .n_rst(n_rst), .wen(wen), .wdata(wdata),
    .strobe_expanded(strobe_expanded), .reg_select(reg_select),
    .tcnt(tcnt), .nxt_tcnt(nxt_tcnt), .tcr(tcr), .nxt_tcr(nxt_tcr),
    .tpsc(tpsc), .tarr(tarr), .t_uirq(t_uirq)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic w, input int idx, input logic [W-1:0] d,
                              input logic [W-1:0] stb, input logic [W-1:0] e_tcnt,
                              input logic [W-1:0] e_tcr, input logic [W-1:0] e_tarr,
                              input logic e_u);
    vec_t v;
    v.w = w; v.idx = idx; v.d = d; v.stb = stb;
    v.e_tcnt = e_tcnt; v.e_tcr = e_tcr; v.e_tarr = e_tarr; v.e_u = e_u;
    return v;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input int idx, input logic [W-1:0] d,
                       input logic [W-1:0] stb);
    wen             = w;
    wdata           = d;
    strobe_expanded = stb;
    reg_select      = '0;
    if (idx >= 0 && idx < NR) reg_select[idx] = 1'b1;
  endtask

  task automatic compare();
    logic [SBW-1:0] e, a;
    string nm;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got output with no expected entry");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = {tcnt, tcr, tarr, t_uirq};
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got tcnt=%h tcr=%h tarr=%h uirq=%b expected tcnt=%h tcr=%h tarr=%h uirq=%b",
               nm, a[96:65], a[64:33], a[32:1], a[0], e[96:65], e[64:33], e[32:1], e[0]);
    end
  endtask

  // One clock: drive at negedge, push expectation, compare after the edge
  task automatic cycle(input logic w, input int idx, input logic [W-1:0] d,
                       input logic [W-1:0] stb, input logic [W-1:0] e_tcnt,
                       input logic [W-1:0] e_tcr, input logic [W-1:0] e_tarr,
                       input logic e_u, input string nm);
    drive(w, idx, d, stb);
    exp_q.push_back({e_tcnt, e_tcr, e_tarr, e_u});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    drive(1'b0, -1, '0, ONES);
    compare();
    @(negedge clk);
  endtask

  task automatic idle(input logic [W-1:0] e_tcnt, input logic [W-1:0] e_tcr,
                      input logic [W-1:0] e_tarr, input logic e_u, input string nm);
    cycle(1'b0, -1, '0, ONES, e_tcnt, e_tcr, e_tarr, e_u, nm);
  endtask

  task automatic do_reset();
    drive(1'b0, -1, '0, ONES);
    n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] exp_cnt;
    do_reset();

    // Reset state
    check("rst_tcnt", tcnt, '0);
    check("rst_tcr", tcr, '0);
    check("rst_tpsc", tpsc, '0);
    check("rst_tarr", tarr, ONES);
    check("rst_uirq", {31'd0, t_uirq}, '0);
    check("rst_nxt_tcnt", nxt_tcnt, '0);

    // Vector table: tpsc=0/tarr=3 wrap, W1C, masked writes, tarr=0
    vecs.push_back(mk(1, I_TARR, 3,      ONES, 0, 0,     3, 0));
    vecs.push_back(mk(1, I_TPSC, 0,      ONES, 0, 0,     3, 0));
    vecs.push_back(mk(1, I_TCR,  'h84,   ONES, 0, 'h84,  3, 0));
    vecs.push_back(mk(0, I_TCNT, 0,      ONES, 1, 'h84,  3, 0));
    vecs.push_back(mk(0, -1,     0,      ONES, 2, 'h84,  3, 0));
    vecs.push_back(mk(0, -1,     0,      ONES, 3, 'h84,  3, 0));
    vecs.push_back(mk(0, -1,     0,      ONES, 0, 'h184, 3, 1));
    vecs.push_back(mk(0, -1,     0,      ONES, 1, 'h184, 3, 1));
    vecs.push_back(mk(1, I_TCR,  'h184,  ONES, 2, 'h84,  3, 0));
    vecs.push_back(mk(0, -1,     0,      ONES, 3, 'h84,  3, 0));
    vecs.push_back(mk(1, I_TCR,  'h184,  ONES, 0, 'h184, 3, 1));
    vecs.push_back(mk(1, I_TCR,  'h100,  ONES, 1, 0,     3, 0));
    vecs.push_back(mk(0, -1,     0,      ONES, 1, 0,     3, 0));
    vecs.push_back(mk(1, 5,      'hAB,   ONES, 1, 0,     3, 0));
    vecs.push_back(mk(0, I_TARR, 'h77,   ONES, 1, 0,     3, 0));
    vecs.push_back(mk(1, I_TARR, 'h12345678, 'h0000FFFF, 1, 0, 'h5678, 0));
    vecs.push_back(mk(1, I_TCR,  'hFFFFFE68, ONES, 1, 0, 'h5678, 0));
    vecs.push_back(mk(1, I_TCNT, 'hAA55, 'hFF,  'h55, 0, 'h5678, 0));
    vecs.push_back(mk(1, I_TARR, 0,      ONES, 'h55, 0,  0, 0));
    vecs.push_back(mk(1, I_TCNT, 5,      ONES, 5, 0,     0, 0));
    vecs.push_back(mk(1, I_TCR,  'h84,   ONES, 5, 'h84,  0, 0));
    vecs.push_back(mk(0, -1,     0,      ONES, 0, 'h184, 0, 1));
    vecs.push_back(mk(0, -1,     0,      ONES, 0, 'h184, 0, 1));
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].w, vecs[i].idx, vecs[i].d, vecs[i].stb, vecs[i].e_tcnt,
            vecs[i].e_tcr, vecs[i].e_tarr, vecs[i].e_u, $sformatf("vec%0d", i));
    end

    // Prescaler tpsc=2: nxt_tcnt leads tcnt only in tick cycles
    do_reset();
    cycle(1, I_TARR, 5, ONES, 0, 0, 5, 0, "psc_tarr");
    cycle(1, I_TPSC, 2, ONES, 0, 0, 5, 0, "psc_tpsc");
    check("psc_tpsc_reg", tpsc, 2);
    cycle(1, I_TCR, 'h80, ONES, 0, 'h80, 5, 0, "psc_en");
    exp_cnt = '0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("psc_nxt%0d", k), nxt_tcnt, (k % 3 == 2) ? exp_cnt + 1 : exp_cnt);
      if (k % 3 == 2) exp_cnt = exp_cnt + 1;
      idle(exp_cnt, 'h80, 5, 0, $sformatf("psc_cnt%0d", k));
    end

    // One-pulse mode, UIF clear, EN write winning over OPM stop
    do_reset();
    cycle(1, I_TARR, 2, ONES, 0, 0, 2, 0, "opm_tarr");
    cycle(1, I_TCR, 'h86, ONES, 0, 'h86, 2, 0, "opm_en");
    idle(1, 'h86, 2, 0, "opm_c1");
    idle(2, 'h86, 2, 0, "opm_c2");
    idle(0, 'h106, 2, 1, "opm_wrap");
    idle(0, 'h106, 2, 1, "opm_hold1");
    idle(0, 'h106, 2, 1, "opm_hold2");
    cycle(1, I_TCR, 'h106, ONES, 0, 'h006, 2, 0, "opm_w1c");
    cycle(1, I_TCR, 'h86, ONES, 0, 'h86, 2, 0, "opm_re_en");
    idle(1, 'h86, 2, 0, "opm_r1");
    idle(2, 'h86, 2, 0, "opm_r2");
    cycle(1, I_TCR, 'h86, ONES, 0, 'h186, 2, 1, "opm_en_write_wins");
    idle(1, 'h186, 2, 1, "opm_keeps_running");

    // Auto-reload preload on/off
    do_reset();
    cycle(1, I_TARR, 9, ONES, 0, 0, 9, 0, "arpe_tarr9");
    cycle(1, I_TCR, 'h90, ONES, 0, 'h90, 9, 0, "arpe_en");
    idle(1, 'h90, 9, 0, "arpe_c1");
    idle(2, 'h90, 9, 0, "arpe_c2");
    cycle(1, I_TARR, 4, ONES, 3, 'h90, 9, 0, "arpe_shadow_wr");
    for (int v = 4; v <= 9; v++) idle(v, 'h90, 9, 0, $sformatf("arpe_old%0d", v));
    idle(0, 'h190, 4, 0, "arpe_reload");
    for (int v = 1; v <= 4; v++) idle(v, 'h190, 4, 0, $sformatf("arpe_new%0d", v));
    idle(0, 'h190, 4, 0, "arpe_wrap4");
    cycle(1, I_TCR, 'h80, ONES, 1, 'h180, 4, 0, "arpe_off");
    cycle(1, I_TARR, 9, ONES, 2, 'h180, 9, 0, "direct_tarr9");
    for (int v = 3; v <= 5; v++) idle(v, 'h180, 9, 0, $sformatf("direct_c%0d", v));
    cycle(1, I_TARR, 4, ONES, 6, 'h180, 4, 0, "direct_tarr4");
    idle(0, 'h180, 4, 0, "direct_wrap_ge");

    // RST beats TCNT write; TCNT write leaves the prescaler phase alone
    do_reset();
    cycle(1, I_TPSC, 2, ONES, 0, 0, ONES, 0, "rst_tpsc");
    cycle(1, I_TCR, 'h80, ONES, 0, 'h80, ONES, 0, "rst_en");
    idle(0, 'h80, ONES, 0, "rst_p1");
    idle(0, 'h80, ONES, 0, "rst_p2");
    idle(1, 'h80, ONES, 0, "rst_p3");
    idle(1, 'h80, ONES, 0, "rst_p4");
    cycle(1, I_TCR, 'h81, ONES, 1, 'h81, ONES, 0, "rst_set");
    drive(1'b1, I_TCNT, 7, ONES);
    #1;
    check("rst_nxt_tcnt_win", nxt_tcnt, 0);
    check("rst_nxt_tcr_clr", nxt_tcr, 'h80);
    cycle(1, I_TCNT, 7, ONES, 0, 'h80, ONES, 0, "rst_vs_tcnt_wr");
    idle(0, 'h80, ONES, 0, "rst_after1");
    cycle(1, I_TCNT, 7, ONES, 7, 'h80, ONES, 0, "tcnt_wr7");
    idle(8, 'h80, ONES, 0, "tcnt_wr_psc_kept");

    // Asynchronous reset mid-count
    do_reset();
    cycle(1, I_TARR, 2, ONES, 0, 0, 2, 0, "ar_tarr");
    cycle(1, I_TPSC, 1, ONES, 0, 0, 2, 0, "ar_tpsc");
    cycle(1, I_TCR, 'h84, ONES, 0, 'h84, 2, 0, "ar_en");
    idle(0, 'h84, 2, 0, "ar_c0");
    idle(1, 'h84, 2, 0, "ar_c1");
    idle(1, 'h84, 2, 0, "ar_c2");
    idle(2, 'h84, 2, 0, "ar_c3");
    idle(2, 'h84, 2, 0, "ar_c4");
    idle(0, 'h184, 2, 1, "ar_wrap");
    #2;
    n_rst = 1'b0;
    #1;
    check("ar_tcnt", tcnt, '0);
    check("ar_tcr", tcr, '0);
    check("ar_tpsc", tpsc, '0);
    check("ar_tarr", tarr, ONES);
    check("ar_uirq", {31'd0, t_uirq}, '0);
    check("ar_nxt_tcnt", nxt_tcnt, '0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
